axi_wr_burst_engine: RTL and testbench
======================================

Name: axi_wr_burst_engine

Overview:
- Sits directly downstream of the I/O controller's write-request port.
- Accepts burst commands (wr_req/wr_len/wr_address), queues them, and drives the AXI4 AW channel.
- Streams decompressed 64 B beats from the decompressor output onto the AXI W channel, generating WLAST per burst.
- Returns B-channel completions to the I/O controller as single-cycle bresp pulses.

Parameters:
- DATA_W, 512, W-channel data width in bits (64 B per beat)
- ADDR_W, 64, address width
- CMD_DEPTH, 4, command queue depth (power of 2, ≥2); maximum bursts accepted but not yet fully written

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_req  in  1  burst request from I/O controller; held high until acknowledged
- wr_len  in  8  beats−1 of the requested burst
- wr_address  in  ADDR_W  burst start address
- wr_req_ack  out  1  combinational accept pulse
- awvalid  out  1  AXI AW valid
- awready  in  1  AXI AW ready
- awaddr  out  ADDR_W  AXI AW address
- awlen  out  8  AXI AW length
- awsize  out  3  constant 3'b110
- awburst  out  2  constant 2'b01 (INCR)
- din_valid  in  1  decompressed data valid
- din_ready  out  1  decompressed data ready
- din_data  in  DATA_W  decompressed data
- wvalid  out  1  AXI W valid
- wready  in  1  AXI W ready
- wdata  out  DATA_W  AXI W data
- wstrb  out  DATA_W/8  constant all ones
- wlast  out  1  AXI W last
- bvalid  in  1  AXI B valid
- bresp_code  in  2  AXI BRESP
- bready_i  in  1  B-channel ready from I/O controller
- bready  out  1  AXI B ready (equals bready_i)
- bresp  out  1  one-cycle completion pulse to I/O controller
- wr_err  out  1  sticky: any BRESP ≠ 2'b00
- idle  out  1  both queues empty and no W burst active

Behaviour:
- **Reset** (async, rst=1): both queues empty, beat counter 0, burst_active 0, wr_err 0.
  - Reset values: awvalid=0, wvalid=0, din_ready=0, wlast=0, bresp=0, wr_req_ack=0, idle=1.
  - Reset mid-burst discards all queued and in-flight state; no recovery of partial bursts.
- **Accept**: wr_req_ack = wr_req & ~cmd_full.
  - On ack, {wr_address, wr_len} is pushed into the AW queue and wr_len into the W-length queue in the same cycle.
  - Ack must be combinational: the upstream controller advances address/length on the ack edge and presents the next request in the following cycle.
  - A registered ack is forbidden (it causes double acceptance).
- **Full condition**: cmd_full = outstanding count == CMD_DEPTH.
  - outstanding increments on accept and decrements on the wlast handshake (wvalid & wready & wlast).
  - Simultaneous accept and decrement leaves the count unchanged.
  - Accept is still refused while full, even if a decrement occurs in that cycle (conservative).
- **AW channel**: awvalid = AW queue non-empty; awaddr/awlen driven from the queue head; pop on awvalid & awready. No combinational path from awready to awvalid.
- **W channel FSM** (states W_IDLE, W_BURST):
  - W_IDLE → W_BURST when the W-length queue is non-empty: pop head into len_r, beat_cnt=0.
  - In W_BURST:
    - wvalid = din_valid
    - din_ready = wready
    - wdata = din_data
    - wlast = (beat_cnt == len_r)
  - On each handshake beat_cnt+1.
  - On the wlast handshake → W_IDLE, or directly reload from the queue if it is non-empty (back-to-back bursts with no bubble).
  - In W_IDLE: wvalid=0, din_ready=0.
- **Channel independence**: W data may precede the AW handshake of the same burst (AXI permitted); W never starts a burst not yet accepted.
- **B channel**:
  - bresp = bvalid & bready_i.
  - wr_err set when bresp is pulsed with bresp_code ≠ 0; cleared only by rst.
- **Arithmetic**: beat_cnt is 8 bits; wr_len=0 gives a single-beat burst with wlast on the first beat; wr_len=8'hFF is legal (256 beats).

Optional Feature:
- Macro: AXI_WR_DATA_REG_EN
- Defined:
  - A 2-entry skid buffer is inserted between the W FSM output and the AXI W ports.
  - wdata/wvalid/wlast are registered, adding exactly 1 cycle of latency.
  - din_ready is driven from the buffer's not-full state, so there is no combinational wready→din_ready path.
  - Throughput stays 1 beat/cycle.
- Undefined: combinational pass-through as described in Behaviour; zero added latency.

Test Plan:
- Single request wr_len=0x3F, addr=0x1000, awready=1, wready=1, din_valid=1:
  - ack in cycle 0; awvalid with awaddr=0x1000, awlen=0x3F.
  - 64 W beats with wlast only on beat 63; idle returns to 1 after the B pulse.
- Held wr_req with upstream advancing address by 4096 each ack, CMD_DEPTH=4, awready=0:
  - exactly 4 acks, then ack=0 until the first wlast handshake frees a slot.
- Back-to-back bursts of len 0x3F and 0x05 with continuous data: 70 W beats with no idle cycle; wlast on beats 63 and 69.
- wr_len=0: a single beat carries wlast=1; randomized wready/din_valid stalls preserve data order and beat count.
- bvalid with bresp_code=2'b10: bresp pulses for one cycle and wr_err=1 stays set. A following OKAY response pulses bresp and leaves wr_err at 1.
- Assert rst mid-burst (beat 20 of 64):
  - all outputs return to reset values asynchronously.
  - a new request afterwards completes normally with wlast at the correct beat.

Source files
------------

// File: rtl/axi_wr_burst_engine_if.sv
// AXI4 write-address, write-data and write-response signals seen by the burst engine.
// master: the engine side (drives AW/W, BREADY); slave: the memory/interconnect side.
// Pure wiring, no state.
interface axi_wr_burst_engine_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wlast;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp_code;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid, bresp_code
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bresp_code
  );
endinterface

// File: rtl/axi_wr_burst_engine.sv
// AXI4 write burst engine: queues burst commands, drives AW, streams beats to W with WLAST, pulses B completions.
// Latency: AW one cycle after accept; W pass-through adds 0 cycles (1 cycle with AXI_WR_DATA_REG_EN defined).
// Backpressure: accept refused while CMD_DEPTH bursts are outstanding; din_ready follows wready (or skid not-full).
module axi_wr_burst_engine #(
  parameter int DATA_W    = 512,
  parameter int ADDR_W    = 64,
  parameter int CMD_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_req,
  input  logic [7:0]          wr_len,
  input  logic [ADDR_W-1:0]   wr_address,
  output logic                wr_req_ack,
  input  logic                din_valid,
  output logic                din_ready,
  input  logic [DATA_W-1:0]   din_data,
  input  logic                bready_i,
  output logic                bresp,
  output logic                wr_err,
  output logic                idle,
  axi_wr_burst_engine_if.master axi
);
  localparam int CNT_W = $clog2(CMD_DEPTH) + 1;

  typedef enum logic {W_IDLE, W_BURST} w_state_e;

  logic                 cmd_full, aw_full, aw_empty, aw_pop;
  logic                 wq_full, wq_empty, wq_pop;
  logic [ADDR_W+7:0]    aw_head;
  logic [7:0]           wq_head;
  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  w_state_e             state_q, state_d;
  logic [7:0]           len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic                 wr_err_q, wr_err_d;
  logic                 fsm_vld, fsm_rdy, fsm_last, fsm_hs;
  logic                 wlast_hs, w_drained;

  // The AW queue is twice as deep as the outstanding limit because W may run
  // ahead of AW and retire bursts whose address is still queued; its full flag
  // only guards that corner and never trips while AW keeps up.
  assign cmd_full   = (outstanding_q == CNT_W'(CMD_DEPTH));
  assign wr_req_ack = wr_req & ~cmd_full & ~aw_full & ~wq_full;

  axi_wr_fifo #(.W(ADDR_W + 8), .DEPTH(2 * CMD_DEPTH)) u_aw_q (
    .clk(clk), .rst(rst),
    .wr_en(wr_req_ack), .wr_dat({wr_address, wr_len}),
    .rd_en(aw_pop), .rd_dat(aw_head),
    .empty(aw_empty), .full(aw_full)
  );

  axi_wr_fifo #(.W(8), .DEPTH(CMD_DEPTH)) u_wlen_q (
    .clk(clk), .rst(rst),
    .wr_en(wr_req_ack), .wr_dat(wr_len),
    .rd_en(wq_pop), .rd_dat(wq_head),
    .empty(wq_empty), .full(wq_full)
  );

  // awvalid comes straight from the queue occupancy register, so awready never reaches it
  assign axi.awvalid = ~aw_empty;
  assign axi.awaddr  = aw_head[ADDR_W+7:8];
  assign axi.awlen   = aw_head[7:0];
  assign axi.awsize  = 3'b110;
  assign axi.awburst = 2'b01;
  assign aw_pop      = axi.awvalid & axi.awready;

  // W burst sequencer: loads a length, counts beats, reloads on the last beat without a bubble
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    wq_pop     = 1'b0;
    fsm_vld    = 1'b0;
    fsm_last   = 1'b0;
    fsm_hs     = 1'b0;
    din_ready  = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (!wq_empty) begin
          wq_pop     = 1'b1;
          len_d      = wq_head;
          beat_cnt_d = 8'd0;
          state_d    = W_BURST;
        end
      end
      W_BURST: begin
        fsm_vld   = din_valid;
        fsm_last  = (beat_cnt_q == len_q);
        din_ready = fsm_rdy;
        fsm_hs    = din_valid & fsm_rdy;
        if (fsm_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (fsm_last) begin
            if (!wq_empty) begin
              wq_pop     = 1'b1;
              len_d      = wq_head;
              beat_cnt_d = 8'd0;
            end else begin
              state_d = W_IDLE;
            end
          end
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

`ifdef AXI_WR_DATA_REG_EN
  logic              skid_full, skid_empty;
  logic [DATA_W:0]   skid_head;

  axi_wr_fifo #(.W(DATA_W + 1), .DEPTH(2)) u_skid (
    .clk(clk), .rst(rst),
    .wr_en(fsm_hs), .wr_dat({fsm_last, din_data}),
    .rd_en(axi.wvalid & axi.wready), .rd_dat(skid_head),
    .empty(skid_empty), .full(skid_full)
  );

  assign fsm_rdy    = ~skid_full;
  assign axi.wvalid = ~skid_empty;
  assign axi.wdata  = skid_head[DATA_W-1:0];
  assign axi.wlast  = skid_head[DATA_W] & ~skid_empty;
  assign w_drained  = skid_empty;
`else
  assign fsm_rdy    = axi.wready;
  assign axi.wvalid = fsm_vld;
  assign axi.wdata  = din_data;
  assign axi.wlast  = fsm_last;
  assign w_drained  = 1'b1;
`endif

  assign axi.wstrb = '1;
  assign wlast_hs  = axi.wvalid & axi.wready & axi.wlast;

  // Outstanding bursts: +1 on accept, -1 when the burst's last beat leaves on W
  always_comb begin
    outstanding_d = outstanding_q;
    case ({wr_req_ack, wlast_hs})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  assign axi.bready = bready_i;
  assign bresp      = axi.bvalid & bready_i;
  assign wr_err     = wr_err_q;
  assign idle       = aw_empty & wq_empty & (state_q == W_IDLE) & w_drained;

  // Sticky error: any completed response that is not OKAY
  always_comb begin
    wr_err_d = wr_err_q | (bresp & (axi.bresp_code != 2'b00));
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= W_IDLE;
      len_q         <= 8'd0;
      beat_cnt_q    <= 8'd0;
      outstanding_q <= '0;
      wr_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      beat_cnt_q    <= beat_cnt_d;
      outstanding_q <= outstanding_d;
      wr_err_q      <= wr_err_d;
    end
  end
endmodule

// Generic synchronous FIFO; caller never pushes when full or pops when empty.
// Latency: data readable the cycle after push; head is a mux off the storage.
// Backpressure: full/empty flags only, no internal protection.
module axi_wr_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_en,
  output logic [W-1:0] rd_dat,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(DEPTH));
  assign rd_dat = mem_q[rd_ptr_q];

  // Pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(rd_en);
    cnt_d    = cnt_q + CW'(wr_en) - CW'(rd_en);
  end

  // Storage write; contents need no reset since occupancy gates their use
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_dat;
  end

  // Pointer/count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_axi_wr_burst_engine.sv
// Directed bench for axi_wr_burst_engine: single burst, held requests against the outstanding
// limit, back-to-back bursts, single-beat and stalled bursts, B responses, and mid-burst reset.
module tb_axi_wr_burst_engine;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_req;
  logic [7:0]        wr_len;
  logic [ADDR_W-1:0] wr_address;
  logic              wr_req_ack;
  logic              din_valid;
  logic              din_ready;
  logic [DATA_W-1:0] din_data;
  logic              bready_i;
  logic              bresp;
  logic              wr_err;
  logic              idle;

  int total = 0;
  int bad   = 0;
  int seq   = 0;
  bit rnd_mode = 1'b0;

  axi_wr_burst_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi_if ();

  axi_wr_burst_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CMD_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_len(wr_len), .wr_address(wr_address), .wr_req_ack(wr_req_ack),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .bready_i(bready_i), .bresp(bresp), .wr_err(wr_err), .idle(idle),
    .axi(axi_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input int s);
    logic [63:0] w;
    w = 64'hA5A5_0000_0000_0000 | 64'(s);
    return {8{w}};
  endfunction

  // Advance one clock; feed the next data word if the current one was taken.
  task automatic adv();
    bit hs;
    hs = din_valid && din_ready;
    @(posedge clk);
    #1;
    if (hs) seq++;
    din_data = pat(seq);
    if (rnd_mode) begin
      din_valid     = ($urandom_range(0, 3) != 0);
      axi_if.wready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Watch W for nb beats: data order, wlast only at beats la/lb, and span when unstalled.
  task automatic run_w(input string tag, input int nb, input int la, input int lb, input bit rnd);
    int beat;
    int first;
    int last;
    int cyc;
    logic [DATA_W-1:0] exp_d;
    beat = 0; first = -1; last = -1; cyc = 0;
    rnd_mode = rnd;
    while (beat < nb && cyc < 2000) begin
      @(negedge clk);
      if (axi_if.wvalid && axi_if.wready) begin
        exp_d = pat(beat);
        chk({tag, "_dlo"}, axi_if.wdata[63:0], exp_d[63:0]);
        chk({tag, "_dhi"}, axi_if.wdata[511:448], exp_d[511:448]);
        chk({tag, "_last"}, axi_if.wlast, (beat == la || beat == lb));
        if (first < 0) first = cyc;
        last = cyc;
        beat++;
      end
      adv();
      cyc++;
    end
    rnd_mode      = 1'b0;
    din_valid     = 1'b1;
    axi_if.wready = 1'b1;
    chk({tag, "_beats"}, beat, nb);
    if (!rnd) chk({tag, "_span"}, last - first + 1, nb);
  endtask

  initial begin
    int  acks;
    int  wl;
    bit  ackd;
    bit  found;
    bit  done;

    rst = 1'b1;
    wr_req = 1'b0; wr_len = 8'd0; wr_address = '0;
    din_valid = 1'b0; din_data = pat(0); bready_i = 1'b1;
    axi_if.awready = 1'b0; axi_if.wready = 1'b0;
    axi_if.bvalid = 1'b0; axi_if.bresp_code = 2'b00;

    // reset values
    @(negedge clk);
    chk("rst_awvalid", axi_if.awvalid, 0);
    chk("rst_wvalid", axi_if.wvalid, 0);
    chk("rst_din_ready", din_ready, 0);
    chk("rst_wlast", axi_if.wlast, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_ack", wr_req_ack, 0);
    chk("rst_idle", idle, 1);
    chk("rst_wr_err", wr_err, 0);
    chk("const_awsize", axi_if.awsize, 3'b110);
    chk("const_awburst", axi_if.awburst, 2'b01);
    chk("const_wstrb_lo", axi_if.wstrb[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    rst = 1'b0;

    // single 64-beat burst
    axi_if.awready = 1'b1; axi_if.wready = 1'b1; din_valid = 1'b1;
    seq = 0; din_data = pat(0);
    wr_req = 1'b1; wr_len = 8'h3F; wr_address = 64'h1000;
    @(negedge clk);
    chk("t1_ack", wr_req_ack, 1);
    adv();
    wr_req = 1'b0;
    @(negedge clk);
    chk("t1_awvalid", axi_if.awvalid, 1);
    chk("t1_awaddr", axi_if.awaddr, 64'h1000);
    chk("t1_awlen", axi_if.awlen, 8'h3F);
    adv();
    run_w("t1", 64, 63, 63, 1'b0);
    axi_if.bvalid = 1'b1; axi_if.bresp_code = 2'b00;
    @(negedge clk);
    chk("t1_bresp", bresp, 1);
    chk("t1_bready", axi_if.bready, 1);
    adv();
    axi_if.bvalid = 1'b0;
    @(negedge clk);
    chk("t1_bresp_off", bresp, 0);
    chk("t1_idle", idle, 1);
    chk("t1_wr_err", wr_err, 0);
    adv();

    // held request against the outstanding limit, AW stalled
    seq = 0; din_data = pat(0); din_valid = 1'b0; axi_if.awready = 1'b0;
    wr_len = 8'd1; wr_address = 64'h10000; wr_req = 1'b1; acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ackd = wr_req_ack;
      if (ackd) acks++;
      adv();
      if (ackd) wr_address = wr_address + 64'd4096;
    end
    chk("t2_acks", acks, 4);
    @(negedge clk);
    chk("t2_ack_off", wr_req_ack, 0);
    chk("t2_awvalid", axi_if.awvalid, 1);
    chk("t2_awaddr", axi_if.awaddr, 64'h10000);
    chk("t2_awlen", axi_if.awlen, 8'd1);
    adv();
    din_valid = 1'b1;
    wl = 0; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (axi_if.wvalid && axi_if.wready && axi_if.wlast) begin
        wl++;
        found = 1'b1;
        chk("t2_ack_at_wlast", wr_req_ack, 0);
      end
      adv();
    end
    chk("t2_wlast_seen", found, 1);
    @(negedge clk);
    chk("t2_ack_after_free", wr_req_ack, 1);
    adv();
    wr_req = 1'b0; axi_if.awready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (axi_if.wvalid && axi_if.wready && axi_if.wlast) wl++;
      done = idle;
      adv();
    end
    @(negedge clk);
    chk("t2_drain_idle", idle, 1);
    chk("t2_wlasts", wl, 5);
    adv();

    // back-to-back bursts of 64 and 6 beats
    seq = 0; din_data = pat(0);
    wr_req = 1'b1; wr_len = 8'h3F; wr_address = 64'h20000;
    @(negedge clk);
    chk("t3_ack0", wr_req_ack, 1);
    adv();
    wr_len = 8'h05; wr_address = 64'h21000;
    @(negedge clk);
    chk("t3_ack1", wr_req_ack, 1);
    adv();
    wr_req = 1'b0;
    run_w("t3", 70, 63, 69, 1'b0);
    @(negedge clk);
    chk("t3_idle", idle, 1);
    adv();

    // single-beat burst and a stalled 8-beat burst
    seq = 0; din_data = pat(0);
    wr_req = 1'b1; wr_len = 8'h00; wr_address = 64'h30000;
    @(negedge clk);
    chk("t4_ack", wr_req_ack, 1);
    adv();
    wr_req = 1'b0;
    run_w("t4_len0", 1, 0, 0, 1'b1);
    seq = 0; din_data = pat(0);
    wr_req = 1'b1; wr_len = 8'h07; wr_address = 64'h31000;
    @(negedge clk);
    chk("t4s_ack", wr_req_ack, 1);
    adv();
    wr_req = 1'b0;
    run_w("t4_stall", 8, 7, 7, 1'b1);
    @(negedge clk);
    chk("t4_idle", idle, 1);
    adv();

    // B responses: SLVERR sets the sticky error, OKAY leaves it set
    axi_if.bvalid = 1'b1; axi_if.bresp_code = 2'b10; bready_i = 1'b0;
    @(negedge clk);
    chk("t5_bresp_blocked", bresp, 0);
    chk("t5_bready_low", axi_if.bready, 0);
    chk("t5_err_blocked", wr_err, 0);
    adv();
    bready_i = 1'b1;
    @(negedge clk);
    chk("t5_bresp_err", bresp, 1);
    adv();
    axi_if.bvalid = 1'b0;
    @(negedge clk);
    chk("t5_bresp_off", bresp, 0);
    chk("t5_wr_err_set", wr_err, 1);
    adv();
    axi_if.bvalid = 1'b1; axi_if.bresp_code = 2'b00;
    @(negedge clk);
    chk("t5_bresp_ok", bresp, 1);
    adv();
    axi_if.bvalid = 1'b0;
    @(negedge clk);
    chk("t5_bresp_off2", bresp, 0);
    chk("t5_wr_err_kept", wr_err, 1);
    adv();

    // reset in the middle of a 64-beat burst
    seq = 0; din_data = pat(0);
    wr_req = 1'b1; wr_len = 8'h3F; wr_address = 64'h50000;
    @(negedge clk);
    chk("t6_ack", wr_req_ack, 1);
    adv();
    wr_req = 1'b0;
    run_w("t6_pre", 20, 63, 63, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_awvalid", axi_if.awvalid, 0);
    chk("t6_wvalid", axi_if.wvalid, 0);
    chk("t6_din_ready", din_ready, 0);
    chk("t6_wlast", axi_if.wlast, 0);
    chk("t6_bresp", bresp, 0);
    chk("t6_ack_rst", wr_req_ack, 0);
    chk("t6_idle", idle, 1);
    chk("t6_wr_err", wr_err, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    seq = 0; din_data = pat(0);
    wr_req = 1'b1; wr_len = 8'h03; wr_address = 64'h40000;
    @(negedge clk);
    chk("t6_post_ack", wr_req_ack, 1);
    adv();
    wr_req = 1'b0;
    @(negedge clk);
    chk("t6_post_awaddr", axi_if.awaddr, 64'h40000);
    chk("t6_post_awlen", axi_if.awlen, 8'h03);
    adv();
    run_w("t6_post", 4, 3, 3, 1'b0);
    @(negedge clk);
    chk("t6_post_idle", idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
